mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the single unified memory bus of the multicycle RV32I core. Master 0 is the core's memory port: instruction fetch plus load/store during the memory state. Master 1 is a secondary requester such as the program loader or a debug/DMA port. The block sequences each transfer through a small FSM and applies round-robin on simultaneous requests. It tolerates a variable-latency slave and bounds every access with a timeout that returns an error.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Unified memory bus between the two requesting masters, the arbiter and the memory slave.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_wren;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic                  m1_req;
  logic                  m1_wren;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_wren;
  logic                  s_rden;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_ready;

  modport slave (
    input  m0_req, m0_wren, m0_addr, m0_wdata,
    input  m1_req, m1_wren, m1_addr, m1_wdata,
    input  s_rdata, s_ready,
    output m0_ack, m0_err, m1_ack, m1_err, m_rdata,
    output s_addr, s_wdata, s_wren, s_rden
  );

  modport master (
    output m0_req, m0_wren, m0_addr, m0_wdata,
    output m1_req, m1_wren, m1_addr, m1_wdata,
    output s_rdata, s_ready,
    input  m0_ack, m0_err, m1_ack, m1_err, m_rdata,
    input  s_addr, s_wdata, s_wren, s_rden
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the single memory bus, with a bounded wait on the slave
// that completes with an error on timeout.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus,
  output logic [1:0]          arb_state,
  output logic                arb_owner
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  own_wren;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  busy, done;

  assign own_wren  = owner_q ? bus.m1_wren  : bus.m0_wren;
  assign own_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
  assign own_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          // On a tie the master that did not win last time gets the bus.
          owner_d = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
          last_d  = owner_d;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.s_ready) begin
          if (!own_wren) rdata_d = bus.s_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);

  // Slave side is driven only while a transfer is in flight.
  assign bus.s_wren  = busy & own_wren;
  assign bus.s_rden  = busy & ~own_wren;
  assign bus.s_addr  = busy ? own_addr : '0;
  assign bus.s_wdata = busy ? own_wdata : '0;

  assign bus.m0_ack  = done & ~owner_q;
  assign bus.m1_ack  = done & owner_q;
  assign bus.m0_err  = done & ~owner_q & err_q;
  assign bus.m1_err  = done & owner_q & err_q;
  assign bus.m_rdata = done ? rdata_q : '0;

  assign arb_state = state_q;
  assign arb_owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT_CYCLES=8; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] arb_state;
  logic       arb_owner;
  int         checks;
  int         failures;

  mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .arb_state(arb_state),
    .arb_owner(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_m0_ack"},  32'(bus.m0_ack),  32'd0);
    check_eq({tag, "_m1_ack"},  32'(bus.m1_ack),  32'd0);
    check_eq({tag, "_m0_err"},  32'(bus.m0_err),  32'd0);
    check_eq({tag, "_m1_err"},  32'(bus.m1_err),  32'd0);
    check_eq({tag, "_s_wren"},  32'(bus.s_wren),  32'd0);
    check_eq({tag, "_s_rden"},  32'(bus.s_rden),  32'd0);
    check_eq({tag, "_s_addr"},  bus.s_addr,       32'd0);
    check_eq({tag, "_s_wdata"}, bus.s_wdata,      32'd0);
    check_eq({tag, "_m_rdata"}, bus.m_rdata,      32'd0);
    check_eq({tag, "_state"},   32'(arb_state),   32'd0);
  endtask

  initial begin
    logic exp_owner;
    checks   = 0;
    failures = 0;
    rst          = 1'b0;
    bus.m0_req   = 1'b1;
    bus.m0_wren  = 1'b0;
    bus.m0_addr  = 32'h0000_0010;
    bus.m0_wdata = 32'h0;
    bus.m1_req   = 1'b1;
    bus.m1_wren  = 1'b0;
    bus.m1_addr  = 32'h0000_0020;
    bus.m1_wdata = 32'h0;
    bus.s_rdata  = 32'h5555_AAAA;
    bus.s_ready  = 1'b0;

    // Reset held two cycles with both masters requesting.
    @(negedge clk); check_all_zero("rst1");
    @(negedge clk); check_all_zero("rst2");
    rst = 1'b1;

    // First grant after reset goes to master 0 on a tie.
    @(negedge clk);
    check_eq("first_state", 32'(arb_state), 32'd1);
    check_eq("first_owner", 32'(arb_owner), 32'd0);
    bus.m1_req  = 1'b0;
    bus.s_ready = 1'b1;
    @(negedge clk);
    check_eq("first_ack", 32'(bus.m0_ack), 32'd1);
    bus.m0_req = 1'b0;
    @(negedge clk);
    check_eq("first_idle", 32'(arb_state), 32'd0);

    // Zero-wait read by master 0.
    bus.m0_req  = 1'b1;
    bus.m0_wren = 1'b0;
    bus.m0_addr = 32'h0000_0100;
    bus.s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("zw_rden", 32'(bus.s_rden), 32'd1);
    check_eq("zw_wren", 32'(bus.s_wren), 32'd0);
    check_eq("zw_addr", bus.s_addr, 32'h0000_0100);
    check_eq("zw_ack_early", 32'(bus.m0_ack), 32'd0);
    @(negedge clk);
    check_eq("zw_ack", 32'(bus.m0_ack), 32'd1);
    check_eq("zw_err", 32'(bus.m0_err), 32'd0);
    check_eq("zw_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    check_eq("zw_m1_ack", 32'(bus.m1_ack), 32'd0);
    check_eq("zw_rden_off", 32'(bus.s_rden), 32'd0);
    bus.m0_req = 1'b0;
    @(negedge clk);
    check_eq("zw_idle", 32'(arb_state), 32'd0);
    check_eq("zw_ack_off", 32'(bus.m0_ack), 32'd0);

    // Master 1 read with four slave wait cycles.
    bus.m1_req  = 1'b1;
    bus.m1_wren = 1'b0;
    bus.m1_addr = 32'h0000_0400;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("ws_rden%0d", k), 32'(bus.s_rden), 32'd1);
      check_eq($sformatf("ws_addr%0d", k), bus.s_addr, 32'h0000_0400);
      check_eq($sformatf("ws_ack%0d", k), 32'(bus.m1_ack), 32'd0);
      if (k == 5) bus.s_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("ws_ack", 32'(bus.m1_ack), 32'd1);
    check_eq("ws_err", 32'(bus.m1_err), 32'd0);
    check_eq("ws_rdata", bus.m_rdata, 32'hCAFE_F00D);
    check_eq("ws_m0_ack", 32'(bus.m0_ack), 32'd0);
    check_eq("ws_rden_off", 32'(bus.s_rden), 32'd0);
    bus.m1_req = 1'b0;
    @(negedge clk);
    check_eq("ws_idle", 32'(arb_state), 32'd0);

    // Round-robin: both masters write continuously; last winner was master 1.
    bus.m0_req   = 1'b1;
    bus.m0_wren  = 1'b1;
    bus.m0_addr  = 32'h0000_0200;
    bus.m0_wdata = 32'h1111_1111;
    bus.m1_req   = 1'b1;
    bus.m1_wren  = 1'b1;
    bus.m1_addr  = 32'h0000_0300;
    bus.m1_wdata = 32'h2222_2222;
    for (int g = 0; g < 4; g++) begin
      exp_owner = g[0];
      @(negedge clk);
      check_eq($sformatf("rr_owner%0d", g), 32'(arb_owner), 32'(exp_owner));
      check_eq($sformatf("rr_wren%0d", g), 32'(bus.s_wren), 32'd1);
      check_eq($sformatf("rr_rden%0d", g), 32'(bus.s_rden), 32'd0);
      check_eq($sformatf("rr_wdata%0d", g), bus.s_wdata,
               exp_owner ? 32'h2222_2222 : 32'h1111_1111);
      check_eq($sformatf("rr_addr%0d", g), bus.s_addr,
               exp_owner ? 32'h0000_0300 : 32'h0000_0200);
      @(negedge clk);
      check_eq($sformatf("rr_ack0_%0d", g), 32'(bus.m0_ack), 32'(!exp_owner));
      check_eq($sformatf("rr_ack1_%0d", g), 32'(bus.m1_ack), 32'(exp_owner));
      check_eq($sformatf("rr_rdata%0d", g), bus.m_rdata, 32'hCAFE_F00D);
      if (g == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("rr_idle%0d", g), 32'(arb_state), 32'd0);
      check_eq($sformatf("rr_noack%0d", g), 32'(bus.m0_ack | bus.m1_ack), 32'd0);
    end

    // Timeout: slave never ready, error completion at t+9.
    bus.m0_req  = 1'b1;
    bus.m0_wren = 1'b0;
    bus.m0_addr = 32'h0000_0500;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h1234_5678;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("to_busy%0d", k), 32'(arb_state), 32'd1);
      check_eq($sformatf("to_ack%0d", k), 32'(bus.m0_ack), 32'd0);
    end
    @(negedge clk);
    check_eq("to_ack", 32'(bus.m0_ack), 32'd1);
    check_eq("to_err", 32'(bus.m0_err), 32'd1);
    check_eq("to_rdata", bus.m_rdata, 32'd0);
    check_eq("to_m1_err", 32'(bus.m1_err), 32'd0);
    bus.m0_req = 1'b0;
    @(negedge clk);
    check_eq("to_idle", 32'(arb_state), 32'd0);

    // Ready on the last allowed BUSY cycle beats the timeout.
    bus.m0_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("tr_busy%0d", k), 32'(arb_state), 32'd1);
      if (k == 8) bus.s_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("tr_ack", 32'(bus.m0_ack), 32'd1);
    check_eq("tr_err", 32'(bus.m0_err), 32'd0);
    check_eq("tr_rdata", bus.m_rdata, 32'h1234_5678);
    bus.m0_req  = 1'b0;
    bus.s_ready = 1'b0;
    @(negedge clk);
    check_eq("tr_idle", 32'(arb_state), 32'd0);

    // Reset during a waiting master 1 access.
    bus.m1_req  = 1'b1;
    bus.m1_wren = 1'b0;
    bus.m1_addr = 32'h0000_0600;
    @(negedge clk);
    check_eq("rb_owner", 32'(arb_owner), 32'd1);
    check_eq("rb_rden1", 32'(bus.s_rden), 32'd1);
    @(negedge clk);
    check_eq("rb_rden2", 32'(bus.s_rden), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rb_state", 32'(arb_state), 32'd0);
    check_eq("rb_rden_off", 32'(bus.s_rden), 32'd0);
    check_eq("rb_wren_off", 32'(bus.s_wren), 32'd0);
    check_eq("rb_ack", 32'(bus.m1_ack), 32'd0);
    rst        = 1'b1;
    bus.m1_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("rb_noack%0d", k), 32'(bus.m1_ack), 32'd0);
      check_eq($sformatf("rb_idle%0d", k), 32'(arb_state), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
